background_fb: RTL and testbench
================================

Name: background_fb

Overview:
- Parametrised successor of the single-bank background store.
- Column-major framebuffer: pixel index = y + HEIGHT*x.
- Adds a registered read port with valid, a gated host write port, and a hardware fill engine that clears the whole buffer to one colour.
- Sits between the scene loader, which writes and fills, and the VGA/pixel pipeline, which reads.

Parameters:
- WIDTH, 320, pixel columns.
- HEIGHT, 240, pixel rows.
- COLOR_W, 4, bits per stored pixel (colour index).
- Derived, not overridable:
  - XW = $clog2(WIDTH)
  - YW = $clog2(HEIGHT)
  - DEPTH = WIDTH*HEIGHT
  - AW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_x  in  XW  read column.
- rd_y  in  YW  read row.
- rd_data  out  COLOR_W  pixel read one cycle after rd_en.
- rd_valid  out  1  rd_data is valid this cycle.
- wr_en  in  1  host write request.
- wr_addr  in  AW  linear write index.
- wr_data  in  COLOR_W  host write colour.
- wr_ready  out  1  high when a host write is accepted this cycle.
- fill_start  in  1  single-cycle pulse; start a fill.
- fill_color  in  COLOR_W  fill colour, sampled on an accepted fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  single-cycle pulse at fill completion.
- swap_req  in  1  present only with FB_DOUBLE_BUF_EN.
- front_bank  out  1  present only with FB_DOUBLE_BUF_EN.

Behaviour:
- Reset:
  - rst_n low clears rd_data, rd_valid, fill_busy and fill_done to 0.
  - The FSM returns to IDLE.
  - wr_ready is 1 once in IDLE.
  - Memory contents are not reset.
- Read path:
  - raddr = rd_y + HEIGHT*rd_x, computed at AW bits.
  - rd_valid(t+1) = rd_en(t).
  - rd_data(t+1) = mem[raddr(t)].
  - If rd_x >= WIDTH or rd_y >= HEIGHT: rd_data = 0 and rd_valid still 1.
  - When rd_en = 0, rd_data holds its last value.
  - Reads are serviced in every state, including during a fill.
- Same-address read and write in one cycle: read-before-write, so the old data is returned.
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - wr_ready = 1.
    - wr_en with wr_addr < DEPTH writes mem[wr_addr] = wr_data.
    - wr_addr >= DEPTH is dropped silently.
    - fill_start: latch fill_color, clear the AW-bit counter, go to FILL.
    - fill_start together with wr_en in the same cycle: the host write is performed and the fill starts next cycle.
  - FILL:
    - fill_busy = 1 and wr_ready = 0.
    - Each cycle writes mem[cnt] = latched colour, then cnt++.
    - The write at cnt = DEPTH-1 is the last one, then go to DONE.
    - Fill takes exactly DEPTH cycles.
    - fill_start is ignored; wr_en is ignored (dropped, not queued).
  - DONE:
    - One cycle with fill_done = 1, fill_busy = 0, wr_ready = 0.
    - Then go to IDLE.
- Reset during FILL: immediate return to IDLE.
  - No fill_done pulse.
  - Memory is left partially filled.

Optional Feature:
- Macro: FB_DOUBLE_BUF_EN.
- Defined:
  - Two DEPTH-entry banks.
  - Reads use bank front_bank; host writes and fills target bank ~front_bank.
  - front_bank resets to 0.
  - swap_req in IDLE: front_bank toggles on the next edge.
  - swap_req in FILL or DONE: the request is latched and the toggle happens on the DONE->IDLE edge.
  - Multiple pending swap requests collapse into one toggle.
  - A read issued in the same cycle as the toggle uses the old front bank.
- Not defined:
  - Single bank.
  - swap_req and front_bank ports are absent.
  - Behaviour is exactly as above.

Test Plan:
- Write then read:
  - Stimulus: wr_en, wr_addr = 5+240*3 (725), wr_data = 0xA; next cycle rd_en with rd_x = 3, rd_y = 5.
  - Required: rd_valid = 1 and rd_data = 0xA exactly one cycle after rd_en.
- Out of range:
  - Stimulus: rd_en with rd_x = 320, rd_y = 0.
  - Required: next cycle rd_valid = 1 and rd_data = 0. Also wr_addr = 76800 leaves all memory unchanged.
- Fill, run with WIDTH = 8, HEIGHT = 4:
  - Stimulus: fill_start with fill_color = 0x3.
  - Required: fill_busy high for 32 cycles, fill_done pulses once. A sweep of all 32 pixels reads 0x3. A wr_en during busy is dropped and wr_ready = 0.
- Reset mid-fill, run with 8x4:
  - Stimulus: deassert rst_n after 10 fill cycles.
  - Required: fill_busy = 0 immediately, no fill_done pulse. Indices 0-9 = new colour; the rest keep their old values.
- Read-before-write:
  - Stimulus: same-cycle read and write to index 0, old 0x1, new 0x7.
  - Required: rd_data = 0x1; a subsequent read returns 0x7.
- FB_DOUBLE_BUF_EN:
  - Stimulus: fill back bank with 0x5, pulse swap_req during FILL.
  - Required: front_bank toggles 0->1 on the DONE->IDLE edge. Reads return 0x5 afterwards and the old values before.

Source files
------------

// File: rtl/background_fb_if.sv
// Bundle between background_fb and its users: registered read port,
// gated host write port and fill-engine control.
interface background_fb_if #(
    parameter int COLOR_W = 4,
    parameter int XW      = 9,
    parameter int YW      = 8,
    parameter int AW      = 17
);
    logic               rd_en;
    logic [XW-1:0]      rd_x;
    logic [YW-1:0]      rd_y;
    logic [COLOR_W-1:0] rd_data;
    logic               rd_valid;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;
    logic               fill_start;
    logic [COLOR_W-1:0] fill_color;
    logic               fill_busy;
    logic               fill_done;

    modport master (
        output rd_en, rd_x, rd_y,
        output wr_en, wr_addr, wr_data,
        output fill_start, fill_color,
        input  rd_data, rd_valid, wr_ready,
        input  fill_busy, fill_done
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        input  wr_en, wr_addr, wr_data,
        input  fill_start, fill_color,
        output rd_data, rd_valid, wr_ready,
        output fill_busy, fill_done
    );
endinterface

// File: rtl/background_fb.sv
// Column-major background framebuffer with registered read and fill engine.
// Define FB_DOUBLE_BUF_EN for a front/back bank pair with swap_req.
module background_fb #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int COLOR_W = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef FB_DOUBLE_BUF_EN
    input  logic swap_req,
    output logic front_bank,
`endif
    background_fb_if.slave bus
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
`ifdef FB_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int MW = $clog2(NB * DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    logic [COLOR_W-1:0] mem [NB*DEPTH];

    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [COLOR_W-1:0] rd_data_q;
    logic               rd_valid_q;

    logic [XW-1:0]      rx;
    logic [YW-1:0]      ry;
    logic [AW-1:0]      raddr;
    logic               rd_ok;
    logic               wr_ok;
    logic [MW-1:0]      rbase, wbase, ridx, widx;

    logic               we;
    logic [AW-1:0]      waddr;
    logic [COLOR_W-1:0] wdata;
    logic               wr_ready_c, busy_c, done_c;

    assign rx    = bus.rd_x;
    assign ry    = bus.rd_y;
    assign raddr = AW'(ry) + AW'(HEIGHT) * AW'(rx);
    assign rd_ok = (int'(rx) < WIDTH) && (int'(ry) < HEIGHT);
    assign wr_ok = int'(bus.wr_addr) < DEPTH;

`ifdef FB_DOUBLE_BUF_EN
    logic front_q, front_d, pend_q, pend_d;
    assign rbase      = front_q ? MW'(DEPTH) : '0;
    assign wbase      = front_q ? '0 : MW'(DEPTH);
    assign front_bank = front_q;
`else
    assign rbase = '0;
    assign wbase = '0;
`endif

    assign ridx = rbase + MW'(raddr);
    assign widx = wbase + MW'(waddr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        we         = 1'b0;
        waddr      = bus.wr_addr;
        wdata      = bus.wr_data;
        wr_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
`ifdef FB_DOUBLE_BUF_EN
        front_d = front_q;
        pend_d  = pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                wr_ready_c = 1'b1;
                we         = bus.wr_en && wr_ok;
                if (bus.fill_start) begin
                    color_d = bus.fill_color;
                    cnt_d   = '0;
                    state_d = FILL;
                end
`ifdef FB_DOUBLE_BUF_EN
                if (swap_req) front_d = ~front_q;
`endif
            end
            FILL: begin
                busy_c = 1'b1;
                we     = 1'b1;
                waddr  = cnt_q;
                wdata  = color_q;
                if (cnt_q == AW'(DEPTH - 1)) state_d = DONE;
                else cnt_d = cnt_q + 1'b1;
`ifdef FB_DOUBLE_BUF_EN
                if (swap_req) pend_d = 1'b1;
`endif
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
`ifdef FB_DOUBLE_BUF_EN
                // Deferred swaps collapse into a single toggle here.
                if (pend_q || swap_req) front_d = ~front_q;
                pend_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
`ifdef FB_DOUBLE_BUF_EN
            front_q <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
`ifdef FB_DOUBLE_BUF_EN
            front_q <= front_d;
            pend_q  <= pend_d;
`endif
        end
    end

    // Read samples mem before this edge's write lands: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_ok ? mem[ridx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.fill_busy = busy_c;
    assign bus.fill_done = done_c;
endmodule

// File: tb/tb_background_fb.sv
// Directed scoreboard bench: a 320x240 and an 8x4 background_fb.
// With FB_DOUBLE_BUF_EN defined only the bank-swap sequence runs.
module tb_background_fb;
    localparam int BW = 320, BH = 240, SW = 8, SH = 4;
    localparam int BXW = $clog2(BW), BYW = $clog2(BH), BAW = $clog2(BW*BH);
    localparam int SXW = $clog2(SW), SYW = $clog2(SH), SAW = $clog2(SW*SH);

    logic clk = 1'b0;
    logic rst_b, rst_s;
    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    background_fb_if #(.COLOR_W(4), .XW(BXW), .YW(BYW), .AW(BAW)) bb();
    background_fb_if #(.COLOR_W(4), .XW(SXW), .YW(SYW), .AW(SAW)) sb();

`ifdef FB_DOUBLE_BUF_EN
    logic swap_b, swap_s, front_b, front_s;
`endif

    background_fb #(.WIDTH(BW), .HEIGHT(BH), .COLOR_W(4)) u_big (
        .clk(clk), .rst_n(rst_b),
`ifdef FB_DOUBLE_BUF_EN
        .swap_req(swap_b), .front_bank(front_b),
`endif
        .bus(bb)
    );

    background_fb #(.WIDTH(SW), .HEIGHT(SH), .COLOR_W(4)) u_small (
        .clk(clk), .rst_n(rst_s),
`ifdef FB_DOUBLE_BUF_EN
        .swap_req(swap_s), .front_bank(front_s),
`endif
        .bus(sb)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(string tag, logic v, logic [3:0] d);
        chk({tag, "_valid"}, 32'(v), 1);
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk(tag, 32'(d), 32'(exp_q.pop_front()));
    endtask

    task automatic read_b(int x, int y, logic [3:0] e, string tag);
        bb.rd_en = 1'b1; bb.rd_x = BXW'(x); bb.rd_y = BYW'(y);
        exp_q.push_back(e);
        @(negedge clk);
        bb.rd_en = 1'b0;
        pop_chk(tag, bb.rd_valid, bb.rd_data);
    endtask

    task automatic read_s(int i, logic [3:0] e, string tag);
        sb.rd_en = 1'b1; sb.rd_x = SXW'(i / SH); sb.rd_y = SYW'(i % SH);
        exp_q.push_back(e);
        @(negedge clk);
        sb.rd_en = 1'b0;
        pop_chk(tag, sb.rd_valid, sb.rd_data);
    endtask

    task automatic wr_b(int a, logic [3:0] d);
        bb.wr_en = 1'b1; bb.wr_addr = BAW'(a); bb.wr_data = d;
        @(negedge clk);
        bb.wr_en = 1'b0;
    endtask

    task automatic start_fill_s(logic [3:0] c);
        sb.fill_start = 1'b1; sb.fill_color = c;
        @(negedge clk);
        sb.fill_start = 1'b0; sb.fill_color = 4'hF;
    endtask

    task automatic wait_done_s(string tag);
        logic seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            seen = sb.fill_done;
        end
        chk(tag, 32'(seen), 1);
    endtask

    initial begin
        int busy, done, done_at;
        logic [3:0] e;
        rst_b = 1'b0; rst_s = 1'b0;
        bb.rd_en = 0; bb.rd_x = '0; bb.rd_y = '0;
        bb.wr_en = 0; bb.wr_addr = '0; bb.wr_data = '0;
        bb.fill_start = 0; bb.fill_color = '0;
        sb.rd_en = 0; sb.rd_x = '0; sb.rd_y = '0;
        sb.wr_en = 0; sb.wr_addr = '0; sb.wr_data = '0;
        sb.fill_start = 0; sb.fill_color = '0;
`ifdef FB_DOUBLE_BUF_EN
        swap_b = 1'b0; swap_s = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bb.rd_valid), 0);
        chk("rst_data", 32'(bb.rd_data), 0);
        chk("rst_busy", 32'(sb.fill_busy), 0);
        chk("rst_done", 32'(sb.fill_done), 0);
        chk("rst_ready", 32'(sb.wr_ready), 1);
        rst_b = 1'b1; rst_s = 1'b1;
        @(negedge clk);

`ifdef FB_DOUBLE_BUF_EN
        chk("db_rst_front", 32'(front_s), 0);
        start_fill_s(4'h2);
        wait_done_s("db_fill1_done");
        @(negedge clk);
        swap_s = 1'b1;
        @(negedge clk);
        swap_s = 1'b0;
        chk("db_idle_swap", 32'(front_s), 1);
        read_s(5, 4'h2, "db_front1_rd");
        start_fill_s(4'h5);
        done = 0;
        for (int c = 1; c <= 60 && done == 0; c++) begin
            @(negedge clk);
            if (c == 9) begin
                pop_chk("db_rd_during_fill", sb.rd_valid, sb.rd_data);
                sb.rd_en = 1'b0;
            end
            swap_s = (c == 5 || c == 15);
            if (c == 8) begin
                sb.rd_en = 1'b1; sb.rd_x = 3'd2; sb.rd_y = 2'd3;
                exp_q.push_back(4'h2);
            end
            if (c == 20) chk("db_front_held", 32'(front_s), 1);
            if (sb.fill_done) done = 1;
        end
        swap_s = 1'b0;
        chk("db_fill2_done", 32'(done), 1);
        chk("db_front_at_done", 32'(front_s), 1);
        sb.rd_en = 1'b1; sb.rd_x = '0; sb.rd_y = '0;
        exp_q.push_back(4'h2);
        @(negedge clk);
        sb.rd_en = 1'b0;
        pop_chk("db_toggle_cycle_rd", sb.rd_valid, sb.rd_data);
        chk("db_front_after", 32'(front_s), 0);
        read_s(31, 4'h5, "db_new_last");
        read_s(0, 4'h5, "db_new_first");
        @(negedge clk);
        chk("db_single_toggle", 32'(front_s), 0);
`else
        wr_b(725, 4'hA);
        read_b(3, 5, 4'hA, "wr_rd");
        @(negedge clk);
        chk("hold_valid", 32'(bb.rd_valid), 0);
        chk("hold_data", 32'(bb.rd_data), 32'hA);
        wr_b(0, 4'h1);
        wr_b(76799, 4'h6);
        read_b(320, 0, 4'h0, "oor_x");
        read_b(0, 240, 4'h0, "oor_y");
        read_b(319, 239, 4'h6, "last_px");
        wr_b(76800, 4'hF);
        read_b(319, 239, 4'h6, "oor_wr_last");
        read_b(0, 0, 4'h1, "oor_wr_first");
        read_b(3, 5, 4'hA, "oor_wr_mid");
        bb.wr_en = 1'b1; bb.wr_addr = '0; bb.wr_data = 4'h7;
        bb.rd_en = 1'b1; bb.rd_x = '0; bb.rd_y = '0;
        exp_q.push_back(4'h1);
        @(negedge clk);
        bb.wr_en = 1'b0; bb.rd_en = 1'b0;
        pop_chk("rbw_old", bb.rd_valid, bb.rd_data);
        read_b(0, 0, 4'h7, "rbw_new");

        start_fill_s(4'h3);
        busy = 0; done = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (sb.fill_busy) busy++;
            if (sb.fill_done) begin done++; done_at = c; end
            sb.fill_start = (c == 10);
            sb.fill_color = (c == 10) ? 4'h9 : 4'hF;
            if (c == 20) chk("busy_wr_ready", 32'(sb.wr_ready), 0);
            sb.wr_en = (c == 20); sb.wr_addr = 5'd2; sb.wr_data = 4'hE;
            @(negedge clk);
        end
        sb.wr_en = 1'b0; sb.fill_start = 1'b0;
        chk("fill_busy_cycles", 32'(busy), 32);
        chk("fill_done_pulses", 32'(done), 1);
        chk("fill_done_pos", 32'(done_at), 33);
        chk("idle_ready", 32'(sb.wr_ready), 1);
        for (int i = 0; i < SW*SH; i++) read_s(i, 4'h3, $sformatf("fill_px%0d", i));

        sb.fill_start = 1'b1; sb.fill_color = 4'hC;
        sb.wr_en = 1'b1; sb.wr_addr = 5'd20; sb.wr_data = 4'h9;
        @(negedge clk);
        sb.fill_start = 1'b0; sb.wr_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", 32'(sb.fill_busy), 1);
        rst_s = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(sb.fill_busy), 0);
        chk("mid_rst_done", 32'(sb.fill_done), 0);
        done = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) rst_s = 1'b1;
            @(negedge clk);
            if (sb.fill_done) done++;
        end
        chk("mid_no_done", 32'(done), 0);
        chk("mid_ready", 32'(sb.wr_ready), 1);
        for (int i = 0; i < SW*SH; i++) begin
            e = (i < 10) ? 4'hC : ((i == 20) ? 4'h9 : 4'h3);
            read_s(i, e, $sformatf("mid_px%0d", i));
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
